// File: rtl/bcd4_scan_source.sv
// Upstream stage of the 4-digit seven-segment scan: a start/stop BCD up/down counter
// with a free-running 2-bit digit-scan select. Every output comes straight from a flop.
module bcd4_scan_source #(
    parameter int unsigned COUNT_DIV = 100000000,
    parameter int unsigned SCAN_DIV  = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_pulse,
    input  logic       clr_pulse,
    input  logic       up_dn,
    output logic [3:0] q0,
    output logic [3:0] q1,
    output logic [3:0] q2,
    output logic [3:0] q3,
    output logic [1:0] sel,
    output logic       running
);

    localparam int unsigned CntW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam int unsigned ScnW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(COUNT_DIV - 1);
    localparam logic [ScnW-1:0] ScnLast = ScnW'(SCAN_DIV - 1);

    typedef enum logic {StStop, StRun} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [ScnW-1:0]      scan_q, scan_d;
    logic [1:0]           sel_q, sel_d;
    logic [3:0][3:0]      dig_q, dig_d;
    logic                 count_tick;
    logic                 scan_wrap;
    logic                 carry;

    always_comb begin
        state_d = state_q;
        if (start_pulse) begin
            state_d = (state_q == StRun) ? StStop : StRun;
        end

        count_tick = (state_q == StRun) && (cnt_q == CntLast);

        // Prescaler is zero whenever the FSM sits in STOP, so RUN always starts from 0.
        cnt_d = cnt_q;
        if (state_q == StRun) begin
            cnt_d = count_tick ? '0 : cnt_q + 1'b1;
        end
        if (clr_pulse || ((state_q == StRun) && start_pulse)) begin
            cnt_d = '0;
        end

        scan_wrap = (scan_q == ScnLast);
        scan_d    = scan_wrap ? '0 : scan_q + 1'b1;
        sel_d     = sel_q + 2'(scan_wrap);

        // Ripple carry/borrow from the ones digit upward.
        dig_d = dig_q;
        carry = count_tick;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (up_dn) begin
                    carry    = (dig_q[i] >= 4'd9);
                    dig_d[i] = carry ? 4'd0 : dig_q[i] + 4'd1;
                end else begin
                    carry    = (dig_q[i] == 4'd0);
                    dig_d[i] = (carry || dig_q[i] > 4'd9) ? 4'd9 : dig_q[i] - 4'd1;
                end
            end
        end
        if (clr_pulse) begin
            dig_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StStop;
            cnt_q   <= '0;
            scan_q  <= '0;
            sel_q   <= 2'b00;
            dig_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            scan_q  <= scan_d;
            sel_q   <= sel_d;
            dig_q   <= dig_d;
        end
    end

    assign q0      = dig_q[0];
    assign q1      = dig_q[1];
    assign q2      = dig_q[2];
    assign q3      = dig_q[3];
    assign sel     = sel_q;
    assign running = (state_q == StRun);

endmodule

// File: tb/tb_bcd4_scan_source.sv
// Scoreboard bench for bcd4_scan_source: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them as their cycle arrives.
module tb_bcd4_scan_source;

    localparam int unsigned CD = 4;
    localparam int unsigned SD = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_pulse;
    logic       clr_pulse;
    logic       up_dn;
    logic [3:0] q0, q1, q2, q3;
    logic [1:0] sel;
    logic       running;

    bcd4_scan_source #(
        .COUNT_DIV(CD),
        .SCAN_DIV (SD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_pulse(start_pulse),
        .clr_pulse  (clr_pulse),
        .up_dn      (up_dn),
        .q0         (q0),
        .q1         (q1),
        .q2         (q2),
        .q3         (q3),
        .sel        (sel),
        .running    (running)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        logic [15:0]  dig;
        logic         run;
        logic [127:0] name;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   rel   = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // sel advances every SD edges after reset release.
    function automatic logic [1:0] sel_model(input int c);
        return 2'(((c - rel) / int'(SD)) % 4);
    endfunction

    task automatic check(input logic [127:0] name, input logic [15:0] edig, input logic erun,
                         input logic [1:0] esel);
        n_vec++;
        if ({q3, q2, q1, q0} !== edig || running !== erun || sel !== esel) begin
            n_bad++;
            $display("FAIL %0s @cyc %0d: got q=%h running=%b sel=%0d, expected q=%h running=%b sel=%0d",
                     name, cyc, {q3, q2, q1, q0}, running, sel, edig, erun, esel);
        end
    endtask

    task automatic push(input int dk, input logic [15:0] d, input logic r,
                        input logic [127:0] name);
        exp_t e;
        e.cyc  = cyc + dk;
        e.dig  = d;
        e.run  = r;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                if (e.cyc < cyc) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL %0s: expectation for cycle %0d not checked", e.name, e.cyc);
                end else begin
                    check(e.name, e.dig, e.run, sel_model(e.cyc));
                end
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        start_pulse = 1'b0;
        clr_pulse   = 1'b0;
        up_dn       = 1'b1;
        step(2);
        check("in_reset", 16'h0000, 1'b0, 2'd0);
        rst_n = 1'b1;
        rel   = cyc;

        // Idle: sel scans 00,01,10,11,00 changing every 3 cycles.
        for (int k = 0; k <= 12; k++) push(k, 16'h0000, 1'b0, "idle");
        step(12);

        // Run up 10 ticks: 0000 -> 0010 with the q0 9->0 carry.
        start_pulse = 1'b1;
        push(1, 16'h0000, 1'b1, "run_assert");
        push(4, 16'h0000, 1'b1, "pre_tick1");
        push(5, 16'h0001, 1'b1, "tick1");
        push(37, 16'h0009, 1'b1, "tick9");
        push(40, 16'h0009, 1'b1, "pre_tick10");
        push(41, 16'h0010, 1'b1, "carry_q1");
        step(1);
        start_pulse = 1'b0;
        step(40);

        // Clear on the same edge as a tick: clear wins, prescaler restarts.
        step(3);
        clr_pulse = 1'b1;
        push(1, 16'h0000, 1'b1, "clr_tick");
        push(4, 16'h0000, 1'b1, "clr_no_early");
        push(5, 16'h0001, 1'b1, "clr_next_tick");
        step(1);
        clr_pulse = 1'b0;
        step(4);

        // Down through 0000 -> 9999, then up 9999 -> 0000.
        up_dn = 1'b0;
        push(4, 16'h0000, 1'b1, "down_to0");
        push(8, 16'h9999, 1'b1, "borrow_wrap");
        push(12, 16'h0000, 1'b1, "carry_wrap");
        step(8);
        up_dn = 1'b1;
        step(4);

        // Count to 0005, stop, hold, restart.
        push(20, 16'h0005, 1'b1, "at_0005");
        step(20);
        start_pulse = 1'b1;
        push(1, 16'h0005, 1'b0, "stopped");
        push(11, 16'h0005, 1'b0, "hold_mid");
        push(21, 16'h0005, 1'b0, "hold_end");
        step(1);
        start_pulse = 1'b0;
        step(20);
        start_pulse = 1'b1;
        push(1, 16'h0005, 1'b1, "rerun");
        push(4, 16'h0005, 1'b1, "rerun_pre");
        push(5, 16'h0006, 1'b1, "rerun_tick");
        step(1);
        start_pulse = 1'b0;
        step(4);

        // Clear together with stop: both take effect.
        start_pulse = 1'b1;
        clr_pulse   = 1'b1;
        push(1, 16'h0000, 1'b0, "clr_and_stop");
        step(1);
        start_pulse = 1'b0;
        clr_pulse   = 1'b0;

        // Count to 0123, then drop reset between edges.
        start_pulse = 1'b1;
        step(1);
        start_pulse = 1'b0;
        push(491, 16'h0122, 1'b1, "pre_0123");
        push(492, 16'h0123, 1'b1, "at_0123");
        step(492);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", 16'h0000, 1'b0, 2'd0);
        step(1);
        check("rst_held", 16'h0000, 1'b0, 2'd0);
        rst_n = 1'b1;
        rel   = cyc;
        for (int k = 0; k <= 8; k++) push(k, 16'h0000, 1'b0, "post_rst");
        step(9);
        step(2);

        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
